// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and select constants for the packet-aware mux arbiter
// Contents:
//   arb_state_t  arbiter FSM state (IDLE, LOCK_A, LOCK_B)
//   SEL_A/SEL_B  mux select encodings (1 passes stream a, 0 passes stream b)
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_arb_skid.sv
// rtl/mux_arb_skid.sv - 2-entry skid buffer registering the arbiter output stream
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid, in_data, in_last, in_ready    upstream beat interface
//   out_valid, out_data, out_last, out_ready downstream beat interface
// in_ready depends only on the occupancy register, so there is no combinational
// path from out_ready back to the upstream ready.
module mux_arb_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    logic [W:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign {out_last, out_data} = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - packet-aware two-stream arbiter driving the 2:1 mux select
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   a_valid, a_data, a_last, a_ready  stream a
//   b_valid, b_data, b_last, b_ready  stream b
//   o_valid, o_data, o_last, o_ready  muxed output stream
//   s                                 registered mux select, 1 = a, 0 = b
// Build option MUX_ARB_SKID_EN: registers the output through mux_arb_skid;
// otherwise the output path is combinational from the granted stream.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    input  logic         a_last,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    input  logic         b_last,
    output logic         b_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last,
    input  logic         o_ready,
    output logic         s
);

    arb_state_t   state;
    logic         prio;
    logic         sel_q;

    logic         up_valid;
    logic [W-1:0] up_data;
    logic         up_last;
    logic         up_ready;
    logic         pkt_end;

    assign s = sel_q;

    // In a LOCK state sel_q already points at the granted stream, so the data
    // mux can key off it directly; in IDLE it simply follows the held select.
    assign up_data = (sel_q == SEL_A) ? a_data : b_data;
    assign up_last = (sel_q == SEL_A) ? a_last : b_last;

    always_comb begin
        up_valid = 1'b0;
        case (state)
            LOCK_A:  up_valid = a_valid;
            LOCK_B:  up_valid = b_valid;
            default: up_valid = 1'b0;
        endcase
    end

    assign a_ready = (state == LOCK_A) & up_ready;
    assign b_ready = (state == LOCK_B) & up_ready;

    // Packet end is the handshake of the last beat on the arbiter side.
    assign pkt_end = up_valid & up_ready & up_last;

`ifdef MUX_ARB_SKID_EN
    mux_arb_skid #(
        .W(W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (up_valid),
        .in_data  (up_data),
        .in_last  (up_last),
        .in_ready (up_ready),
        .out_valid(o_valid),
        .out_data (o_data),
        .out_last (o_last),
        .out_ready(o_ready)
    );
`else
    assign up_ready = o_ready;
    assign o_valid  = up_valid;
    assign o_data   = up_data;
    assign o_last   = up_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= SEL_B;
            prio  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (a_valid && (!b_valid || prio)) begin
                        state <= LOCK_A;
                        sel_q <= SEL_A;
                    end else if (b_valid) begin
                        state <= LOCK_B;
                        sel_q <= SEL_B;
                    end
                end
                LOCK_A: begin
                    if (pkt_end) begin
                        state <= IDLE;
                        prio  <= 1'b0;
                    end
                end
                LOCK_B: begin
                    if (pkt_end) begin
                        state <= IDLE;
                        prio  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed self-checking bench for mux_arb
module tb_mux_arb;

    localparam int W = 8;
`ifdef MUX_ARB_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_last;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_last;
    logic         b_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         o_last;
    logic         o_ready;
    logic         s;

    mux_arb #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .a_data (a_data),
        .a_last (a_last),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_data (b_data),
        .b_last (b_last),
        .b_ready(b_ready),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_last (o_last),
        .o_ready(o_ready),
        .s      (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] a_q [$];
    logic [8:0] b_q [$];
    logic       a_hs = 1'b0;
    logic       b_hs = 1'b0;
    int         cyc = 0;

    logic [7:0] out_d [$];
    logic       out_l [$];
    logic       out_s [$];
    int         out_c [$];

    int checks = 0;
    int errors = 0;

    // Sample handshakes and output beats mid-cycle.
    always @(negedge clk) begin
        a_hs = a_valid && a_ready;
        b_hs = b_valid && b_ready;
        if (rst_n && o_valid && o_ready) begin
            out_d.push_back(o_data);
            out_l.push_back(o_last);
            out_s.push_back(s);
            out_c.push_back(cyc);
        end
    end

    // Source model: retire accepted beats, then present the next queued beat.
    always @(posedge clk) begin
        cyc++;
        if (a_hs && a_q.size() > 0) void'(a_q.pop_front());
        if (b_hs && b_q.size() > 0) void'(b_q.pop_front());
        a_hs = 1'b0;
        b_hs = 1'b0;
        #1;
        a_valid = (a_q.size() > 0);
        {a_last, a_data} = (a_q.size() > 0) ? a_q[0] : 9'h0;
        b_valid = (b_q.size() > 0);
        {b_last, b_data} = (b_q.size() > 0) ? b_q[0] : 9'h0;
    end

    task automatic start();
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        o_ready = 1'b1;
        a_q.delete();
        b_q.delete();
        out_d.delete();
        out_l.delete();
        out_s.delete();
        out_c.delete();
    endtask

    task automatic release_reset(output int rel);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_q.size() == 0 && b_q.size() == 0 && !o_valid) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain: timed out, a_q=%0d b_q=%0d required 0", name, a_q.size(), b_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int rel;
        start();
        a_q.push_back({1'b1, 8'h11});
        b_q.push_back({1'b1, 8'h22});
        repeat (2) @(negedge clk);
        checks++;
        if (s !== 1'b0 || o_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: s=%b o_valid=%b a_ready=%b b_ready=%b required 0 0 0 0", s, o_valid, a_ready, b_ready);
        end
`ifndef MUX_ARB_SKID_EN
        checks++;
        if (o_data !== 8'h22) begin
            errors++;
            $display("FAIL reset_o_data: got %h required 22", o_data);
        end
`endif
        release_reset(rel);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_lock_a: s=%b a_ready=%b b_ready=%b required 1 1 0", s, a_ready, b_ready);
        end
`ifndef MUX_ARB_SKID_EN
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_release_out: o_valid=%b o_data=%h required 1 11", o_valid, o_data);
        end
`endif
        wait_drain("reset");
        checks++;
        if (out_d.size() != 2 || out_d[0] !== 8'h11 || out_d[1] !== 8'h22) begin
            errors++;
            $display("FAIL reset_order: %0d beats first=%h required 2 beats 11,22", out_d.size(), (out_d.size() > 0) ? out_d[0] : 8'hxx);
        end
    endtask

    task automatic test_tie();
        int rel;
        logic [7:0] exp_d [12];
        int         exp_off [12];
        exp_d   = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hA3, 8'hA4, 8'hA5, 8'hB3, 8'hB4, 8'hB5};
        exp_off = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};
        start();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                a_q.push_back({(k == 2), 8'hA0 + 8'(p * 3 + k)});
                b_q.push_back({(k == 2), 8'hB0 + 8'(p * 3 + k)});
            end
        end
        release_reset(rel);
        wait_drain("tie");
        checks++;
        if (out_d.size() != 12) begin
            errors++;
            $display("FAIL tie_count: got %0d beats required 12", out_d.size());
        end
        for (int i = 0; i < 12 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_d[i] || out_l[i] !== (i % 3 == 2) ||
                out_c[i] !== rel + LAT + exp_off[i] || out_s[i] !== (exp_d[i][7:4] == 4'hA)) begin
                errors++;
                $display("FAIL tie_beat%0d: data=%h last=%b s=%b cyc=%0d required data=%h last=%b s=%b cyc=%0d",
                         i, out_d[i], out_l[i], out_s[i], out_c[i], exp_d[i], (i % 3 == 2),
                         (exp_d[i][7:4] == 4'hA), rel + LAT + exp_off[i]);
            end
        end
    endtask

    task automatic test_single_beat();
        int rel;
        start();
        for (int k = 0; k < 4; k++) a_q.push_back({1'b1, 8'h30 + 8'(k)});
        release_reset(rel);
        wait_drain("single");
        checks++;
        if (out_d.size() != 4) begin
            errors++;
            $display("FAIL single_count: got %0d beats required 4", out_d.size());
        end
        for (int i = 0; i < 4 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== 8'h30 + 8'(i) || out_l[i] !== 1'b1 || out_s[i] !== 1'b1 ||
                out_c[i] !== rel + LAT + 2 * i) begin
                errors++;
                $display("FAIL single_beat%0d: data=%h last=%b s=%b cyc=%0d required %h 1 1 %0d",
                         i, out_d[i], out_l[i], out_s[i], out_c[i], 8'h30 + 8'(i), rel + LAT + 2 * i);
            end
        end
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL single_s_hold: s=%b required 1", s);
        end
    endtask

    task automatic test_backpressure();
        int rel;
        bit seen = 0;
        start();
        for (int k = 0; k < 3; k++) b_q.push_back({(k == 2), 8'h40 + 8'(k)});
        release_reset(rel);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (out_d.size() >= 1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_first_beat: timed out, beats=%0d required 1", out_d.size());
        end
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'h41 || o_last !== 1'b0 || s !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: o_valid=%b o_data=%h o_last=%b s=%b required 1 41 0 0", i, o_valid, o_data, o_last, s);
            end
`ifndef MUX_ARB_SKID_EN
            checks++;
            if (b_ready !== 1'b0 || b_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_b_ready%0d: b_ready=%b b_valid=%b required 0 1", i, b_ready, b_valid);
            end
`endif
        end
        @(posedge clk);
        #2;
        o_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (out_d.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d beats required 3", out_d.size());
        end
        for (int i = 0; i < 3 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== 8'h40 + 8'(i) || out_l[i] !== (i == 2) || out_s[i] !== 1'b0) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%h last=%b s=%b required %h %b 0", i, out_d[i], out_l[i], out_s[i], 8'h40 + 8'(i), (i == 2));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int rel;
        bit seen = 0;
        start();
        for (int k = 0; k < 4; k++) a_q.push_back({(k == 3), 8'h50 + 8'(k)});
        release_reset(rel);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (out_d.size() >= 2) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_two_beats: timed out, beats=%0d required 2", out_d.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || s !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_reset: o_valid=%b s=%b a_ready=%b required 0 0 0", o_valid, s, a_ready);
        end
        a_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || s !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle: o_valid=%b s=%b a_ready=%b b_ready=%b required 0 0 0 0", o_valid, s, a_ready, b_ready);
            end
        end
        checks++;
        if (out_d.size() != 2) begin
            errors++;
            $display("FAIL midrst_count: got %0d beats required 2", out_d.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        o_ready = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        a_last  = 1'b0;
        b_valid = 1'b0;
        b_data  = '0;
        b_last  = 1'b0;
        test_reset();
        test_tie();
        test_single_beat();
        test_backpressure();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
